// File: rtl/truth_table_checker_if.sv
// Control, status and gate-facing signals of the truth table checker.
// The checker sits on the slave side; the bench or harness sits on the master side.
interface truth_table_checker_if #(
  parameter int unsigned N_IN = 2
);
  logic            start;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN-1:0] fail_index;
  logic            fail_actual;
  logic [N_IN:0]   fail_count;
  logic [N_IN:0]   vec_count;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;

  modport master (
    output start, dut_out,
    input  busy, done, pass, fail_index, fail_actual, fail_count, vec_count, dut_in
  );

  modport slave (
    input  start, dut_out,
    output busy, done, pass, fail_index, fail_actual, fail_count, vec_count, dut_in
  );
endinterface

// File: rtl/truth_table_checker.sv
// Walks every input vector of a combinational gate, waits for it to settle,
// and compares the response against a parameterised truth table.
module truth_table_checker #(
  parameter int unsigned         N_IN         = 2,
  parameter logic [2**N_IN-1:0]  EXPECTED     = 4'b0111,
  parameter int unsigned         SETTLE       = 2,
  parameter bit                  STOP_ON_FAIL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  truth_table_checker_if.slave io
);

  localparam int unsigned NV = 2**N_IN;
  localparam int unsigned IW = N_IN + 1;
  localparam int unsigned CW = 8;
  localparam logic [IW-1:0] LAST = IW'(NV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          exp_bit_c;
  logic          mismatch_c;

  // X or Z on the gate output is treated as a failure.
  assign exp_bit_c  = EXPECTED[idx[N_IN-1:0]];
  assign mismatch_c = (io.dut_out !== exp_bit_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      cnt            <= '0;
      io.dut_in      <= '0;
      io.busy        <= 1'b0;
      io.done        <= 1'b0;
      io.pass        <= 1'b0;
      io.fail_index  <= '0;
      io.fail_actual <= 1'b0;
      io.fail_count  <= '0;
      io.vec_count   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (io.start) begin
            state          <= S_DRIVE;
            idx            <= '0;
            io.busy        <= 1'b1;
            io.done        <= 1'b0;
            io.pass        <= 1'b0;
            io.fail_index  <= '0;
            io.fail_actual <= 1'b0;
            io.fail_count  <= '0;
            io.vec_count   <= '0;
          end
        end
        S_DRIVE: begin
          io.dut_in <= idx[N_IN-1:0];
          cnt       <= CW'(SETTLE - 1);
          state     <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_CHECK;
          else           cnt   <= cnt - CW'(1);
        end
        S_CHECK: begin
          io.vec_count <= io.vec_count + IW'(1);
          if (mismatch_c) begin
            io.fail_count <= io.fail_count + IW'(1);
            // Only the first failing vector is recorded.
            if (io.fail_count == '0) begin
              io.fail_index  <= idx[N_IN-1:0];
              io.fail_actual <= io.dut_out;
            end
          end
          if ((mismatch_c && STOP_ON_FAIL) || (idx == LAST)) begin
            state   <= S_DONE;
            io.busy <= 1'b0;
            io.done <= 1'b1;
            io.pass <= !mismatch_c && (io.fail_count == '0);
          end else begin
            idx   <= idx + IW'(1);
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomised and directed checks of truth_table_checker against a vector-walk model.
// Three instances cover defaults, run-all-vectors mode and a 3-input configuration.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-instance configuration seen by the model.
  int         nvec_of   [3] = '{4, 4, 8};
  int         settle_of [3] = '{2, 2, 1};
  bit         stop_of   [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] exp_of    [3] = '{8'h07, 8'h07, 8'h80};

  // Gate under test per instance: a truth table plus an optional X vector.
  logic [7:0] tbl   [3];
  logic       x_en  [3];
  logic [7:0] x_vec [3];
  logic       st    [3];

  truth_table_checker_if #(.N_IN(2)) if0 ();
  truth_table_checker_if #(.N_IN(2)) if1 ();
  truth_table_checker_if #(.N_IN(3)) if2 ();

  truth_table_checker #(.N_IN(2), .EXPECTED(4'b0111), .SETTLE(2), .STOP_ON_FAIL(1'b1))
    u0 (.clk(clk), .rst(rst), .io(if0));
  truth_table_checker #(.N_IN(2), .EXPECTED(4'b0111), .SETTLE(2), .STOP_ON_FAIL(1'b0))
    u1 (.clk(clk), .rst(rst), .io(if1));
  truth_table_checker #(.N_IN(3), .EXPECTED(8'h80), .SETTLE(1), .STOP_ON_FAIL(1'b1))
    u2 (.clk(clk), .rst(rst), .io(if2));

  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if2.start = st[2];

  always_comb begin
    if0.dut_out = tbl[0][if0.dut_in];
    if (x_en[0] && (8'(if0.dut_in) == x_vec[0])) if0.dut_out = 1'bx;
  end
  always_comb begin
    if1.dut_out = tbl[1][if1.dut_in];
    if (x_en[1] && (8'(if1.dut_in) == x_vec[1])) if1.dut_out = 1'bx;
  end
  always_comb begin
    if2.dut_out = tbl[2][if2.dut_in];
    if (x_en[2] && (8'(if2.dut_in) == x_vec[2])) if2.dut_out = 1'bx;
  end

  // Uniform view of the three instances' outputs.
  logic       o_busy [3], o_done [3], o_pass [3], o_fact [3];
  logic [7:0] o_fidx [3], o_din [3];
  logic [8:0] o_fcnt [3], o_vcnt [3];

  assign o_busy[0] = if0.busy;  assign o_busy[1] = if1.busy;  assign o_busy[2] = if2.busy;
  assign o_done[0] = if0.done;  assign o_done[1] = if1.done;  assign o_done[2] = if2.done;
  assign o_pass[0] = if0.pass;  assign o_pass[1] = if1.pass;  assign o_pass[2] = if2.pass;
  assign o_fact[0] = if0.fail_actual;
  assign o_fact[1] = if1.fail_actual;
  assign o_fact[2] = if2.fail_actual;
  assign o_fidx[0] = 8'(if0.fail_index);
  assign o_fidx[1] = 8'(if1.fail_index);
  assign o_fidx[2] = 8'(if2.fail_index);
  assign o_din[0]  = 8'(if0.dut_in);
  assign o_din[1]  = 8'(if1.dut_in);
  assign o_din[2]  = 8'(if2.dut_in);
  assign o_fcnt[0] = 9'(if0.fail_count);
  assign o_fcnt[1] = 9'(if1.fail_count);
  assign o_fcnt[2] = 9'(if2.fail_count);
  assign o_vcnt[0] = 9'(if0.vec_count);
  assign o_vcnt[1] = 9'(if1.vec_count);
  assign o_vcnt[2] = 9'(if2.vec_count);

  int dq[$];

  // Walk the vectors as the test procedure describes: check each in order,
  // stop at the first bad one if configured, every vector costs SETTLE+2 edges.
  function automatic void model(input int inst, input logic [7:0] t, input int xv,
                                output int fcnt, output int fidx, output logic fact,
                                output int vcnt, output int edges);
    fcnt = 0; fidx = 0; fact = 1'b0; vcnt = 0;
    for (int k = 0; k < nvec_of[inst]; k++) begin
      logic resp;
      resp = (k == xv) ? 1'bx : t[k];
      vcnt++;
      if (resp !== exp_of[inst][k]) begin
        if (fcnt == 0) begin
          fidx = k;
          fact = resp;
        end
        fcnt++;
        if (stop_of[inst]) break;
      end
    end
    edges = vcnt * (settle_of[inst] + 2);
  endfunction

  // Pulse (or hold) start and count edges until done, recording the driven vectors.
  task automatic run(input int inst, input bit hold, output int edges, output bit tmo);
    dq.delete();
    @(negedge clk);
    st[inst] = 1'b1;
    @(posedge clk); #1;
    if (!hold) st[inst] = 1'b0;
    edges = 0;
    tmo   = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      edges++;
      if (dq.size() == 0 || dq[$] != int'(o_din[inst])) dq.push_back(int'(o_din[inst]));
      if (o_done[inst]) break;
      if (edges > 300) begin
        tmo = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({o_busy[i], o_done[i], o_pass[i], o_fact[i], o_fidx[i], o_fcnt[i], o_vcnt[i], o_din[i]} !== 38'd0) begin
        errors++;
        $display("FAIL reset inst%0d busy=%b done=%b pass=%b fcnt=%0d vcnt=%0d din=%0d want all 0",
                 i, o_busy[i], o_done[i], o_pass[i], o_fcnt[i], o_vcnt[i], o_din[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nand_pass();
    int e; bit tmo;
    tbl[0] = 8'h07;
    run(0, 1'b0, e, tmo);
    checks++;
    if (tmo || e != 16) begin errors++; $display("FAIL nand_latency got %0d want 16 (tmo=%0b)", e, tmo); end
    checks++;
    if (dq.size() != 4 || dq[0] != 0 || dq[1] != 1 || dq[2] != 2 || dq[3] != 3) begin
      errors++; $display("FAIL nand_sequence got %p want 0,1,2,3", dq);
    end
    checks++;
    if ({o_pass[0], o_busy[0]} !== 2'b10) begin
      errors++; $display("FAIL nand_pass got pass=%b busy=%b want 1/0", o_pass[0], o_busy[0]);
    end
    checks++;
    if (o_fcnt[0] !== 9'd0 || o_vcnt[0] !== 9'd4) begin
      errors++; $display("FAIL nand_counts got fcnt=%0d vcnt=%0d want 0/4", o_fcnt[0], o_vcnt[0]);
    end
  endtask

  // Run one instance against a gate table and compare everything with the model.
  task automatic test_gate(input string name, input int inst, input logic [7:0] t, input int xv);
    int e, fc, fi, vc, me; bit tmo; logic fa;
    tbl[inst] = t;
    x_en[inst] = (xv >= 0);
    x_vec[inst] = 8'(xv);
    model(inst, t, xv, fc, fi, fa, vc, me);
    run(inst, 1'b0, e, tmo);
    x_en[inst] = 1'b0;
    checks++;
    if (tmo || e != me) begin errors++; $display("FAIL %s_latency inst%0d got %0d want %0d", name, inst, e, me); end
    checks++;
    if (o_fcnt[inst] !== 9'(fc) || o_vcnt[inst] !== 9'(vc)) begin
      errors++; $display("FAIL %s_counts inst%0d got fcnt=%0d vcnt=%0d want %0d/%0d",
                         name, inst, o_fcnt[inst], o_vcnt[inst], fc, vc);
    end
    checks++;
    if (o_fidx[inst] !== 8'(fi) || o_pass[inst] !== (fc == 0)) begin
      errors++; $display("FAIL %s_result inst%0d got fidx=%0d pass=%b want %0d/%b",
                         name, inst, o_fidx[inst], o_pass[inst], fi, (fc == 0));
    end
    if (xv < 0) begin
      checks++;
      if (o_fact[inst] !== fa) begin
        errors++; $display("FAIL %s_actual inst%0d got %b want %b", name, inst, o_fact[inst], fa);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int e; bit tmo;
    tbl[0] = 8'h07;
    @(negedge clk);
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (o_din[0] !== 8'd1 || o_busy[0] !== 1'b1) begin
      errors++; $display("FAIL midrun_vec1 got din=%0d busy=%b want 1/1", o_din[0], o_busy[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({o_busy[0], o_done[0], o_pass[0], o_fact[0], o_fidx[0], o_fcnt[0], o_vcnt[0], o_din[0]} !== 38'd0) begin
      errors++; $display("FAIL midrun_reset got busy=%b done=%b vcnt=%0d din=%0d want all 0",
                         o_busy[0], o_done[0], o_vcnt[0], o_din[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_busy[0] !== 1'b0 || o_done[0] !== 1'b0) begin
      errors++; $display("FAIL midrun_idle got busy=%b done=%b want 0/0", o_busy[0], o_done[0]);
    end
    run(0, 1'b0, e, tmo);
    checks++;
    if (tmo || e != 16 || o_pass[0] !== 1'b1) begin
      errors++; $display("FAIL midrun_rerun got edges=%0d pass=%b want 16/1", e, o_pass[0]);
    end
  endtask

  task automatic test_back_to_back();
    int e; bit tmo;
    tbl[2] = 8'h80;
    run(2, 1'b1, e, tmo);
    checks++;
    if (tmo || e != 24 || o_pass[2] !== 1'b1) begin
      errors++; $display("FAIL held_run got edges=%0d pass=%b want 24/1", e, o_pass[2]);
    end
    @(posedge clk); #1;
    checks++;
    if (o_done[2] !== 1'b0 || o_busy[2] !== 1'b1) begin
      errors++; $display("FAIL held_restart got done=%b busy=%b want 0/1", o_done[2], o_busy[2]);
    end
    st[2] = 1'b0;
    e = 0;
    while (!o_done[2] && e <= 300) begin
      @(posedge clk); #1;
      e++;
    end
    checks++;
    if (e != 24 || o_pass[2] !== 1'b1) begin
      errors++; $display("FAIL held_second got edges=%0d pass=%b want 24/1", e, o_pass[2]);
    end
  endtask

  task automatic test_random();
    int inst;
    logic [7:0] t;
    for (int n = 0; n < 12; n++) begin
      inst = int'($urandom_range(0, 2));
      t = 8'($urandom);
      if (nvec_of[inst] == 4) t[7:4] = 4'h0;
      test_gate("random", inst, t, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; x_en[i] = 1'b0; x_vec[i] = 8'd0; tbl[i] = exp_of[i];
    end
    rst = 1'b0;
    test_reset();
    test_nand_pass();
    test_gate("and_stop", 0, 8'h08, -1);
    test_gate("and_all", 1, 8'h08, -1);
    test_gate("x_vec2", 1, 8'h07, 2);
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Synthesizable stimulus/response engine. It is the DUT-facing end of our gate test flow: it drives every input combination into a combinational gate under test, samples the gate's output, and compares it against a parameterised truth table. It reports pass/fail, the first failing vector, and the failure count, so gate checks (e.g. our_nand) run on-chip or in a bench without hand-written assert lines.

Parameters:
N_IN, 2, number of DUT inputs; 2^N_IN vectors (legal range 1..8)
EXPECTED, 4'b0111, expected output per vector; bit k = expected output for dut_in == k (default = NAND with dut_in = {a,b})
SETTLE, 2, cycles to wait after driving before sampling (legal range 1..255)
STOP_ON_FAIL, 1, 1 = end run at first mismatch; 0 = run all vectors

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin a run; sampled only in IDLE or DONE
dut_in  output  N_IN  vector driven to the DUT
dut_out  input  1  DUT response
busy  output  1  high from the start-accept edge until DONE is entered
done  output  1  high in DONE; held until next accepted start or rst
pass  output  1  valid while done; 1 = zero mismatches
fail_index  output  N_IN  vector index of the first mismatch; 0 if none
fail_actual  output  1  dut_out value sampled at the first mismatch
fail_count  output  N_IN+1  number of mismatching vectors
vec_count  output  N_IN+1  number of vectors checked so far

Behaviour:
- Reset (rst high at a clk edge): state IDLE. dut_in, busy, done, pass, fail_index, fail_actual, fail_count and vec_count all 0. Reset overrides everything, including mid-run; no partial result survives.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1: clear done, pass, fail_*, vec_count and the index; index=0; go to DRIVE; busy=1. start is ignored in DRIVE, SETTLE and CHECK.
- DRIVE (1 cycle): dut_in=index; settle counter=SETTLE-1; go to SETTLE.
- SETTLE: counter decrements once per cycle. At 0, go to CHECK. Occupancy is exactly SETTLE cycles. dut_in stays stable.
- CHECK (1 cycle): sample dut_out and increment vec_count.
  - Mismatch: dut_out !== EXPECTED[index]; X or Z counts as a mismatch. Increment fail_count. On the first mismatch only, latch fail_index=index and fail_actual=dut_out.
  - Next state: if a mismatch occurred and STOP_ON_FAIL=1, go to DONE. Otherwise, if index == 2^N_IN-1, go to DONE. Otherwise, index+1 and go to DRIVE.
- Index arithmetic: N_IN+1 bits internally, so the last-vector compare cannot wrap to 0.
- DONE: busy=0, done=1, pass=(fail_count==0). dut_in holds the last driven vector.
- Latency: each vector takes SETTLE+2 cycles. A full clean run reaches DONE 2^N_IN*(SETTLE+2) edges after the start edge. With defaults that is 16 edges.
- Early stop: with STOP_ON_FAIL=1 and a first failure at vector k, DONE is reached (k+1)*(SETTLE+2) edges after start.
- start high in DONE restarts immediately; the same edge clears done.
- start and rst high together: rst wins.
- dut_out is assumed combinationally driven from dut_in. It is not registered inside the block.

Test Plan:
- our_nand DUT, defaults, pulse start one cycle. Required: dut_in steps 0,1,2,3; done rises 16 edges after start; pass=1, fail_count=0, vec_count=4.
- AND gate as DUT, defaults (EXPECTED=0111). Required: vector 0 mismatches (sampled 0, expected 1); done 4 edges after start; pass=0, fail_index=0, fail_actual=0, fail_count=1, vec_count=1.
- AND gate, STOP_ON_FAIL=0. Required: full 16-edge run; fail_count=4, fail_index=0, vec_count=4, pass=0.
- dut_out forced to X at vector 2, STOP_ON_FAIL=0, DUT otherwise NAND. Required: fail_count=1, fail_index=2, pass=0.
- rst asserted during SETTLE of vector 1. Required: next cycle all outputs 0, state IDLE. A later start gives a clean 16-edge run with pass=1.
- start held high during a run: ignored while busy. When held into DONE, a new run starts on that edge and done drops the following cycle. N_IN=3, SETTLE=1, EXPECTED=8'h80 with a 3-input AND: done after 24 edges, pass=1.
